modbus_req_ctrl: RTL and testbench

Request controller for the Modbus RTU slave. It sits between the frame receiver and the shared UART transmitter, CRC engine and holding-register bank. Each validated request (function code, address, data) is decoded and checked. The controller then performs the register read or write and sequences the response frame (normal or exception) byte by byte through the transmitter, with CRC appended.

---
 rtl/modbus_pkg.sv | 10 +
 rtl/modbus_req_ctrl.sv | 140 ++++++++++++++
 tb/tb_modbus_req_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_pkg.sv
// modbus_pkg: shared Modbus function/exception codes and request controller states
package modbus_pkg;
  localparam logic [7:0] FC_RD_HOLD = 8'h03;
  localparam logic [7:0] FC_WR_SINGLE = 8'h06;
  localparam logic [7:0] EX_ILL_FUNC = 8'h01;
  localparam logic [7:0] EX_ILL_ADDR = 8'h02;
  localparam logic [7:0] EX_ILL_VAL = 8'h03;
  localparam logic [7:0] EX_FLAG = 8'h80;
  typedef enum logic [3:0] {IDLE, DECODE, RD_REQ, RD_LAT, SEND, WAIT_TX, CRC_LO, CRC_HI, DONE} state_t;
endpackage

// File: rtl/modbus_req_ctrl.sv
// modbus_req_ctrl: decodes Modbus RTU requests, accesses registers and sequences the response frame
module modbus_req_ctrl
  import modbus_pkg::*;
#(
  parameter int REG_NUM = 16,
  parameter int MAX_READ = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dev_addr,
  input  logic        rx_message_done,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  output logic        reg_rd_en,
  output logic        reg_wr_en,
  output logic [7:0]  reg_idx,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  output logic        crc_clr,
  output logic        crc_en,
  output logic [7:0]  crc_din,
  input  logic [15:0] crc_out,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        busy,
  output logic        req_dropped
);
  localparam logic [15:0] MAX_Q = 16'(MAX_READ);
  localparam logic [16:0] REG_N = 17'(REG_NUM);
  state_t state, state_nx;
  logic [7:0] fc, ex_code, ex_nx, cnt, n_pay, byte_sel, k;
  logic [15:0] ad, dt, rd_word;
  logic [16:0] rd_end;
  logic ex, capture, hi_next, wr_ok;
  assign busy = state != IDLE && state != DONE;
  assign capture = rx_message_done && !busy;
  assign req_dropped = rx_message_done && busy;
  assign crc_clr = capture;
  assign rd_end = {1'b0, ad} + {1'b0, dt};
  assign ex_nx = (fc != FC_RD_HOLD && fc != FC_WR_SINGLE) ? EX_ILL_FUNC :
                 (fc == FC_RD_HOLD && (dt == 16'd0 || dt > MAX_Q)) ? EX_ILL_VAL :
                 (fc == FC_RD_HOLD && rd_end > REG_N) ? EX_ILL_ADDR :
                 (fc == FC_WR_SINGLE && {1'b0, ad} >= REG_N) ? EX_ILL_ADDR : 8'h00;
  assign wr_ok = ex_nx == 8'h00 && fc == FC_WR_SINGLE;
  assign n_pay = ex ? 8'd3 : fc == FC_WR_SINGLE ? 8'd6 : 8'd3 + {dt[6:0], 1'b0};
  assign k = cnt < 8'd3 ? 8'd0 : (cnt - 8'd3) >> 1;
  assign hi_next = fc == FC_RD_HOLD && !ex && cnt >= 8'd3 && cnt < n_pay && cnt[0];
  always_comb begin
    byte_sel = cnt[0] ? rd_word[15:8] : rd_word[7:0];
    case (cnt)
      8'd0: byte_sel = dev_addr;
      8'd1: byte_sel = ex ? (fc | EX_FLAG) : fc;
      8'd2: byte_sel = ex ? ex_code : fc == FC_RD_HOLD ? {dt[6:0], 1'b0} : ad[15:8];
      8'd3: byte_sel = fc == FC_WR_SINGLE ? ad[7:0] : rd_word[15:8];
      8'd4: byte_sel = fc == FC_WR_SINGLE ? dt[15:8] : rd_word[7:0];
      8'd5: byte_sel = fc == FC_WR_SINGLE ? dt[7:0] : rd_word[15:8];
      default: ;
    endcase
  end
  always_comb begin
    state_nx = state;
    reg_rd_en = 1'b0;
    reg_wr_en = 1'b0;
    reg_idx = 8'd0;
    reg_wdata = 16'd0;
    crc_en = 1'b0;
    crc_din = 8'd0;
    tx_start = 1'b0;
    tx_data = 8'd0;
    case (state)
      IDLE, DONE: state_nx = capture ? DECODE : IDLE;
      DECODE: begin
        state_nx = (ex_nx == 8'h00 && fc == FC_RD_HOLD) ? RD_REQ : SEND;
        reg_wr_en = wr_ok;
        reg_idx = wr_ok ? ad[7:0] : 8'd0;
        reg_wdata = wr_ok ? dt : 16'd0;
      end
      RD_REQ: begin
        reg_rd_en = 1'b1;
        reg_idx = ad[7:0] + k;
        state_nx = RD_LAT;
      end
      RD_LAT: state_nx = SEND;
      SEND: begin
        tx_start = !tx_busy;
        tx_data = byte_sel;
        crc_en = !tx_busy;
        crc_din = byte_sel;
        state_nx = tx_busy ? SEND : WAIT_TX;
      end
      WAIT_TX: state_nx = !tx_done ? WAIT_TX :
                          cnt == n_pay ? CRC_LO :
                          cnt == n_pay + 8'd1 ? CRC_HI :
                          cnt == n_pay + 8'd2 ? DONE :
                          hi_next ? RD_REQ : SEND;
      CRC_LO: begin
        tx_start = !tx_busy;
        tx_data = crc_out[7:0];
        state_nx = tx_busy ? CRC_LO : WAIT_TX;
      end
      CRC_HI: begin
        tx_start = !tx_busy;
        tx_data = crc_out[15:8];
        state_nx = tx_busy ? CRC_HI : WAIT_TX;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fc <= 8'd0;
      ad <= 16'd0;
      dt <= 16'd0;
      ex <= 1'b0;
      ex_code <= 8'd0;
      cnt <= 8'd0;
      rd_word <= 16'd0;
    end else begin
      state <= state_nx;
      if (capture) begin
        fc <= func_code;
        ad <= addr;
        dt <= data;
        ex <= 1'b0;
        ex_code <= 8'd0;
        cnt <= 8'd0;
      end
      if (state == DECODE) begin
        ex <= ex_nx != 8'h00;
        ex_code <= ex_nx;
      end
      if (state == RD_LAT) rd_word <= reg_rdata;
      if (tx_start) cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_modbus_req_ctrl.sv
// tb_modbus_req_ctrl: scoreboard bench with register bank, CRC engine and UART models around the controller
module tb_modbus_req_ctrl;
  localparam int REG_NUM = 16;
  localparam int MAX_READ = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] dev_addr = 8'h01;
  logic rx_message_done = 1'b0;
  logic [7:0] func_code = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic reg_rd_en, reg_wr_en, crc_clr, crc_en, tx_start, tx_busy, tx_done, busy, req_dropped;
  logic [7:0] reg_idx, crc_din, tx_data;
  logic [15:0] reg_wdata, reg_rdata, crc_out;
  logic ubusy, load = 1'b0, hold = 1'b0;
  int ucnt;
  logic [15:0] bank [256];
  logic [15:0] shadow [256];
  logic [7:0] exp_q[$];
  logic [23:0] wr_q[$];
  logic [7:0] e_b;
  logic [23:0] e_w;
  int checks = 0, errors = 0, cyc = 0, r0 = 0, wr_cyc = -1, exp_lat = 0;
  bit exp_wr;

  modbus_req_ctrl #(.REG_NUM(REG_NUM), .MAX_READ(MAX_READ)) dut (
    .clk(clk), .rst_n(rst_n), .dev_addr(dev_addr), .rx_message_done(rx_message_done),
    .func_code(func_code), .addr(addr), .data(data), .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
    .reg_idx(reg_idx), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .crc_clr(crc_clr),
    .crc_en(crc_en), .crc_din(crc_din), .crc_out(crc_out), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .busy(busy), .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tx_busy = ubusy | hold;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always @(posedge clk)
    if (crc_clr) crc_out <= 16'hFFFF;
    else if (crc_en) crc_out <= crc_byte(crc_out, crc_din);

  always @(posedge clk)
    if (load) for (int i = 0; i < 256; i++) bank[i] <= shadow[i];
    else begin
      if (reg_wr_en) bank[reg_idx] <= reg_wdata;
      if (reg_rd_en) reg_rdata <= bank[reg_idx];
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ubusy <= 1'b0;
      ucnt <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) begin
        ubusy <= 1'b1;
        ucnt <= $urandom_range(2, 6);
      end else if (ubusy) begin
        if (ucnt == 0) begin
          ubusy <= 1'b0;
          tx_done <= 1'b1;
        end else ucnt <= ucnt - 1;
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      if (tx_start) begin
        checks++;
        if (tx_busy) begin
          errors++;
          $display("FAIL tx_start_busy tx_busy=%0b required 0", tx_busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte got 0x%02h required no byte", tx_data);
        end else begin
          e_b = exp_q.pop_front();
          if (tx_data !== e_b) begin
            errors++;
            $display("FAIL tx_byte got 0x%02h required 0x%02h", tx_data, e_b);
          end
        end
      end
      if (reg_wr_en) begin
        wr_cyc = cyc;
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL reg_write got %0h/%0h required no write", reg_idx, reg_wdata);
        end else begin
          e_w = wr_q.pop_front();
          if ({reg_idx, reg_wdata} !== e_w) begin
            errors++;
            $display("FAIL reg_write got %0h/%0h required %0h/%0h", reg_idx, reg_wdata, e_w[23:16], e_w[15:0]);
          end
        end
      end
    end

  task automatic issue(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d);
    logic [7:0] f[$];
    logic [15:0] c;
    int ex;
    if (fc != 8'h03 && fc != 8'h06) ex = 1;
    else if (fc == 8'h03 && (d == 0 || int'(d) > MAX_READ)) ex = 3;
    else if (fc == 8'h03 && int'(a) + int'(d) > REG_NUM) ex = 2;
    else if (fc == 8'h06 && int'(a) >= REG_NUM) ex = 2;
    else ex = 0;
    f.push_back(dev_addr);
    exp_wr = 0;
    if (ex != 0) begin
      f.push_back(fc | 8'h80);
      f.push_back(8'(ex));
    end else if (fc == 8'h03) begin
      f.push_back(fc);
      f.push_back(8'(2 * d));
      for (int i = 0; i < int'(d); i++) begin
        f.push_back(shadow[int'(a) + i][15:8]);
        f.push_back(shadow[int'(a) + i][7:0]);
      end
    end else begin
      f.push_back(fc);
      f.push_back(a[15:8]);
      f.push_back(a[7:0]);
      f.push_back(d[15:8]);
      f.push_back(d[7:0]);
      shadow[a[7:0]] = d;
      wr_q.push_back({a[7:0], d});
      exp_wr = 1;
    end
    c = 16'hFFFF;
    foreach (f[i]) c = crc_byte(c, f[i]);
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    foreach (f[i]) exp_q.push_back(f[i]);
    exp_lat = (ex == 0 && fc == 8'h03) ? 4 : 2;
    @(negedge clk);
    func_code = fc;
    addr = a;
    data = d;
    rx_message_done = 1'b1;
    r0 = cyc;
    #1;
    checks++;
    if (req_dropped !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop got %0b required 0", req_dropped);
    end
    @(negedge clk);
    rx_message_done = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got %0b required 1", busy);
    end
    for (int i = 0; i < 100 && !tx_start; i++) @(negedge clk);
    checks++;
    if (!tx_start || cyc - r0 != exp_lat) begin
      errors++;
      $display("FAIL first_tx_latency got %0d required %0d", cyc - r0, exp_lat);
    end
  endtask

  task automatic finish_req(input string name);
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end got %0b required 0", name, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s bytes_left got %0d required 0", name, exp_q.size());
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s writes_left got %0d required 0", name, wr_q.size());
    end
    if (exp_wr) begin
      checks++;
      if (wr_cyc != r0 + 1) begin
        errors++;
        $display("FAIL %s wr_timing got %0d required %0d", name, wr_cyc - r0, 1);
      end
    end
  endtask

  task automatic req(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d, input string name);
    issue(fc, a, d);
    finish_req(name);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    for (int i = 0; i < 2000 && k < n; i++) begin
      @(negedge clk);
      if (tx_start) k++;
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL wait_tx got %0d required %0d", k, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] fc;
    logic [15:0] a, d;
    for (int i = 0; i < 256; i++) shadow[i] = 16'($urandom);
    shadow[0] = 16'hA1B2;
    shadow[1] = 16'hC3D4;
    load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    #1;
    checks++;
    if ({reg_rd_en, reg_wr_en, reg_idx, reg_wdata, crc_clr, crc_en, crc_din, tx_start, tx_data, busy, req_dropped} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero required 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    req(8'h03, 16'h0000, 16'd2, "read2");
    req(8'h06, 16'h0005, 16'h1234, "write5");
    req(8'h10, 16'h0000, 16'h0000, "ill_func");
    req(8'h03, 16'h000F, 16'd2, "rd_range");
    req(8'h03, 16'h0000, 16'd0, "rd_qty0");
    req(8'h03, 16'h0000, 16'd9, "rd_qty9");
    req(8'h03, 16'h0008, 16'd8, "rd_edge");
    req(8'h06, 16'h000F, 16'hBEEF, "wr_edge");
    req(8'h06, 16'h0010, 16'h0001, "wr_range");
    req(8'h03, 16'hFFFF, 16'd2, "rd_wrap");
    for (int n = 0; n < 25; n++) begin
      dev_addr = 8'($urandom);
      case ($urandom_range(0, 4))
        0, 1: begin fc = 8'h03; d = 16'($urandom_range(0, 10)); end
        2, 3: begin fc = 8'h06; d = 16'($urandom); end
        default: begin fc = 8'($urandom); d = 16'($urandom); end
      endcase
      a = 16'($urandom_range(0, 20));
      req(fc, a, d, "random");
    end
    dev_addr = 8'h01;
    issue(8'h03, 16'h0002, 16'd4);
    wait_tx(2);
    hold = 1'b1;
    repeat (8) @(negedge clk);
    func_code = 8'h06;
    addr = 16'h0003;
    data = 16'hFFFF;
    rx_message_done = 1'b1;
    #1;
    checks++;
    if (req_dropped !== 1'b1) begin
      errors++;
      $display("FAIL req_dropped got %0b required 1", req_dropped);
    end
    @(negedge clk);
    rx_message_done = 1'b0;
    repeat (11) @(negedge clk);
    hold = 1'b0;
    finish_req("hold_drop");
    issue(8'h03, 16'h0000, 16'd2);
    wait_tx(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_rd_en, reg_wr_en, reg_idx, reg_wdata, crc_clr, crc_en, crc_din, tx_start, tx_data, busy, req_dropped} !== '0) begin
      errors++;
      $display("FAIL midframe_reset got nonzero required 0");
    end
    exp_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    req(8'h03, 16'h0001, 16'd3, "after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
